// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the Nexys Starship monster controllers:
// one-hot controller states, LFSR tap mask and default seed.
package nexys_starship_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_COOL = 4'b0010,
    ST_ARM  = 4'b0100,
    ST_LIVE = 4'b1000
  } bc_state_t;

  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11; feedback shifts in at bit 0.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with a seed parameter; a zero seed
// would lock up, so it is replaced by the default seed.
module nexys_starship_lfsr16
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [15:0] o_lfsr
);

  localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_lfsr <= INIT;
    else if (i_en) r_lfsr <= lfsr16_next(r_lfsr);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/nexys_starship_bm_ctrl.sv
// Bottom-monster controller: schedules spawns, handshakes them with the
// bottom-monster state machine, resolves shots into kills and counts them.
module nexys_starship_bm_ctrl
  import nexys_starship_pkg::*;
#(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter logic [7:0]  MIN_GAP      = 8'd3,
  parameter logic [3:0]  SPAWN_THRESH = 4'd5,
  parameter logic [7:0]  ACK_TIMEOUT  = 8'd16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       timer_tick,
  input  logic       play_flag,
  input  logic       shoot_pulse,
  input  logic       aim_down,
  input  logic       btm_monster_sm,
  input  logic       btm_gameover,
  output logic       btm_random,
  output logic       btm_monster_ctrl,
  output logic       kill_pulse,
  output logic [7:0] kill_count,
  output logic       ack_err,
  output logic       q_BC_Idle,
  output logic       q_BC_Cool,
  output logic       q_BC_Arm,
  output logic       q_BC_Live
);

  bc_state_t   r_state, w_nxt_state;
  logic [7:0]  r_gap_cnt, w_nxt_gap;
  logic [7:0]  r_ack_cnt, w_nxt_ack;
  logic        r_pending, w_nxt_pending;
  logic        r_killed, w_nxt_killed;
  logic        r_btm_random, w_nxt_random;
  logic        r_ctrl, w_nxt_ctrl;
  logic        r_kill_pulse, w_nxt_kill_pulse;
  logic [7:0]  r_kill_count, w_nxt_kill_count;
  logic        r_ack_err, w_nxt_ack_err;

  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;
  logic        w_ack_expired;
  logic        w_shot;

  nexys_starship_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_en    (1'b1),
    .o_lfsr  (w_lfsr)
  );

  assign w_lfsr_unused = ^w_lfsr[15:4];
  // Expires on the wait cycle in which the count would reach ACK_TIMEOUT.
  assign w_ack_expired = ({1'b0, r_ack_cnt} + 9'd1) >= {1'b0, ACK_TIMEOUT};
  assign w_shot        = shoot_pulse && aim_down;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= ST_IDLE;
      r_gap_cnt    <= '0;
      r_ack_cnt    <= '0;
      r_pending    <= 1'b0;
      r_killed     <= 1'b0;
      r_btm_random <= 1'b0;
      r_ctrl       <= 1'b0;
      r_kill_pulse <= 1'b0;
      r_kill_count <= '0;
      r_ack_err    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_gap_cnt    <= w_nxt_gap;
      r_ack_cnt    <= w_nxt_ack;
      r_pending    <= w_nxt_pending;
      r_killed     <= w_nxt_killed;
      r_btm_random <= w_nxt_random;
      r_ctrl       <= w_nxt_ctrl;
      r_kill_pulse <= w_nxt_kill_pulse;
      r_kill_count <= w_nxt_kill_count;
      r_ack_err    <= w_nxt_ack_err;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_gap        = r_gap_cnt;
    w_nxt_ack        = r_ack_cnt;
    w_nxt_pending    = r_pending;
    w_nxt_killed     = r_killed;
    w_nxt_random     = r_btm_random;
    w_nxt_ctrl       = r_ctrl;
    w_nxt_kill_pulse = 1'b0;
    w_nxt_kill_count = r_kill_count;
    w_nxt_ack_err    = r_ack_err;

    if (r_state != ST_IDLE && btm_gameover) begin
      w_nxt_state   = ST_IDLE;
      w_nxt_random  = 1'b0;
      w_nxt_ctrl    = 1'b0;
      w_nxt_pending = 1'b0;
      w_nxt_killed  = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (play_flag) begin
            w_nxt_state      = ST_COOL;
            w_nxt_gap        = MIN_GAP;
            w_nxt_kill_count = '0;
            w_nxt_ack_err    = 1'b0;
          end
        end
        ST_COOL: begin
          if (r_gap_cnt == '0) begin
            w_nxt_state   = ST_ARM;
            w_nxt_pending = 1'b0;
          end else if (timer_tick) begin
            w_nxt_gap = r_gap_cnt - 8'd1;
          end
        end
        ST_ARM: begin
          if (!r_pending) begin
            if (timer_tick && (w_lfsr[3:0] < SPAWN_THRESH)) begin
              w_nxt_random  = 1'b1;
              w_nxt_ctrl    = 1'b1;
              w_nxt_pending = 1'b1;
              w_nxt_ack     = '0;
            end
          end else if (w_ack_expired) begin
            w_nxt_random  = 1'b0;
            w_nxt_ctrl    = 1'b0;
            w_nxt_pending = 1'b0;
            w_nxt_ack_err = 1'b1;
            w_nxt_state   = ST_COOL;
            w_nxt_gap     = MIN_GAP;
          end else if (btm_monster_sm) begin
            w_nxt_state   = ST_LIVE;
            w_nxt_random  = 1'b0;
            w_nxt_pending = 1'b0;
            w_nxt_killed  = 1'b0;
            w_nxt_ack     = '0;
          end else begin
            w_nxt_ack = r_ack_cnt + 8'd1;
          end
        end
        ST_LIVE: begin
          // Before the kill the monster waits indefinitely; the ack timer
          // only runs once the kill has been issued.
          if (!r_killed) begin
            if (w_shot) begin
              w_nxt_ctrl       = 1'b0;
              w_nxt_kill_pulse = 1'b1;
              w_nxt_killed     = 1'b1;
              w_nxt_ack        = '0;
              w_nxt_kill_count = (r_kill_count == 8'hFF) ? r_kill_count
                                                         : r_kill_count + 8'd1;
            end
          end else if (w_ack_expired) begin
            w_nxt_ack_err = 1'b1;
            w_nxt_state   = ST_COOL;
            w_nxt_gap     = MIN_GAP;
            w_nxt_killed  = 1'b0;
          end else if (!btm_monster_sm) begin
            w_nxt_state  = ST_COOL;
            w_nxt_gap    = MIN_GAP;
            w_nxt_killed = 1'b0;
          end else begin
            w_nxt_ack = r_ack_cnt + 8'd1;
          end
        end
        default: begin
          w_nxt_state   = ST_IDLE;
          w_nxt_random  = 1'b0;
          w_nxt_ctrl    = 1'b0;
          w_nxt_pending = 1'b0;
          w_nxt_killed  = 1'b0;
        end
      endcase
    end
  end

  assign btm_random       = r_btm_random;
  assign btm_monster_ctrl = r_ctrl;
  assign kill_pulse       = r_kill_pulse;
  assign kill_count       = r_kill_count;
  assign ack_err          = r_ack_err;
  assign q_BC_Idle        = (r_state == ST_IDLE);
  assign q_BC_Cool        = (r_state == ST_COOL);
  assign q_BC_Arm         = (r_state == ST_ARM);
  assign q_BC_Live        = (r_state == ST_LIVE);

endmodule
